// File: rtl/toaplan2_cen_wait_pkg.sv
// Shared constants for the Toaplan2 clock-enable wait/compensation logic.
package toaplan2_cen_wait_pkg;

    localparam int DEBT_W_DEF  = 4;
    localparam int MIN_GAP_DEF = 4;
    localparam int B_DLY_DEF   = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN     = 2'd0;
    localparam state_t ST_HOLD    = 2'd1;
    localparam state_t ST_CATCHUP = 2'd2;

endpackage

// File: rtl/toaplan2_cen_wait_delay.sv
// Fixed-length shift line that trails each CEN_OUT pulse with its B companion.
module toaplan2_cen_delay #(
    parameter int B_DLY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse_in,
    output logic pulse_out
);

    logic [B_DLY-1:0] shift_q;
    logic [B_DLY-1:0] shift_d;

    always_comb begin
        shift_d = (shift_q << 1) | B_DLY'(pulse_in);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign pulse_out = shift_q[B_DLY-1];

endmodule

// File: rtl/toaplan2_cen_wait.sv
// Gates a clock-enable pulse train during bus waits and re-issues swallowed
// pulses afterwards, spaced by at least MIN_GAP cycles.
module toaplan2_cen_wait
    import toaplan2_cen_wait_pkg::*;
#(
    parameter int DEBT_W  = DEBT_W_DEF,
    parameter int MIN_GAP = MIN_GAP_DEF,
    parameter int B_DLY   = B_DLY_DEF
) (
    input  logic              CLK96,
    input  logic              RESET96,
    input  logic              CEN_IN,
    input  logic              WAIT,
    output logic              CEN_OUT,
    output logic              CEN_OUT_B,
    output logic              STALLED,
    output logic [DEBT_W-1:0] DEBT,
    output logic              OVERFLOW
);

    localparam int                GAP_W    = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0]  GAP_SAT  = GAP_W'(MIN_GAP);
    localparam logic [DEBT_W-1:0] DEBT_MAX = '1;

    state_t            state_q, state_d;
    logic [DEBT_W-1:0] debt_q, debt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              cen_out_q, cen_out_d;
    logic              overflow_q, overflow_d;
    logic              recovery_ok;

    always_comb begin
        state_d     = state_q;
        debt_d      = debt_q;
        cen_out_d   = 1'b0;
        overflow_d  = overflow_q;
        recovery_ok = (debt_q != '0) && (gap_q >= GAP_SAT);

        if (WAIT) begin
            state_d = ST_HOLD;
            if (CEN_IN) begin
                if (debt_q == DEBT_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    debt_d = debt_q + DEBT_W'(1);
                end
            end
        end else begin
            // A live CEN_IN always wins; recovery only fills otherwise empty slots.
            if (CEN_IN) begin
                cen_out_d = 1'b1;
            end else if (recovery_ok) begin
                cen_out_d = 1'b1;
                debt_d    = debt_q - DEBT_W'(1);
            end
            state_d = (debt_d != '0) ? ST_CATCHUP : ST_RUN;
        end

        // Loaded with 1 on the issuing cycle so consecutive pulses land exactly MIN_GAP apart.
        if (cen_out_d) begin
            gap_d = GAP_W'(1);
        end else if (gap_q >= GAP_SAT) begin
            gap_d = GAP_SAT;
        end else begin
            gap_d = gap_q + GAP_W'(1);
        end
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state_q    <= ST_RUN;
            debt_q     <= '0;
            gap_q      <= GAP_SAT;
            cen_out_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            debt_q     <= debt_d;
            gap_q      <= gap_d;
            cen_out_q  <= cen_out_d;
            overflow_q <= overflow_d;
        end
    end

    toaplan2_cen_delay #(
        .B_DLY(B_DLY)
    ) u_cen_delay (
        .clk      (CLK96),
        .reset    (RESET96),
        .pulse_in (cen_out_q),
        .pulse_out(CEN_OUT_B)
    );

    assign CEN_OUT  = cen_out_q;
    assign STALLED  = (state_q == ST_HOLD);
    assign DEBT     = debt_q;
    assign OVERFLOW = overflow_q;

endmodule
